// File: rtl/imem_pkg.sv
// imem_pkg: shared widths, FSM encoding and requester IDs for the instruction RAM arbiter
package imem_pkg;
  localparam int ADDR_W = 10;
  localparam int DATA_W = 19;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE_RD = 2'd1,
    WAIT_RD  = 2'd2,
    ISSUE_WR = 2'd3
  } state_t;
  localparam logic FETCH  = 1'b0;
  localparam logic LOADER = 1'b1;
endpackage

// File: rtl/imem_arbiter.sv
// imem_arbiter: serialises fetch reads and loader writes onto the single-ported instruction RAM
module imem_arbiter #(
  parameter int ADDR_W = imem_pkg::ADDR_W,
  parameter int DATA_W = imem_pkg::DATA_W,
  parameter int RD_LAT = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_req,
  input  logic [ADDR_W-1:0] fetch_addr,
  output logic              fetch_gnt,
  output logic              fetch_valid,
  output logic [DATA_W-1:0] fetch_data,
  input  logic              ld_req,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic [ADDR_W-1:0] mem_address,
  output logic              mem_read,
  output logic              mem_write,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);
  import imem_pkg::*;
  state_t state, nxt;
  logic rr_last, rr_nxt, pick_ld, rd_done;
  logic [1:0] cnt, cnt_nxt;
  // on a tie the requester that did not win last time goes first
  assign pick_ld = ld_req & (~fetch_req | (rr_last == FETCH));
  assign rd_done = (state == WAIT_RD) && (cnt == 2'd0);
  always_comb begin
    nxt = state;
    cnt_nxt = cnt;
    rr_nxt = rr_last;
    case (state)
      IDLE: begin
        nxt = (fetch_req | ld_req) ? (pick_ld ? ISSUE_WR : ISSUE_RD) : IDLE;
        rr_nxt = (fetch_req & ld_req) ? (pick_ld ? LOADER : FETCH) : rr_last;
      end
      ISSUE_RD: begin
        nxt = WAIT_RD;
        cnt_nxt = 2'(RD_LAT - 1);
      end
      WAIT_RD: begin
        nxt = rd_done ? IDLE : WAIT_RD;
        cnt_nxt = rd_done ? 2'd0 : cnt - 2'd1;
      end
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      rr_last <= FETCH;
      cnt <= 2'd0;
      fetch_gnt <= 1'b0;
      fetch_valid <= 1'b0;
      fetch_data <= '0;
      ld_gnt <= 1'b0;
      mem_address <= '0;
      mem_read <= 1'b0;
      mem_write <= 1'b0;
      mem_wdata <= '0;
      busy <= 1'b0;
    end else begin
      state <= nxt;
      rr_last <= rr_nxt;
      cnt <= cnt_nxt;
      fetch_gnt <= nxt == ISSUE_RD;
      mem_read <= nxt == ISSUE_RD;
      ld_gnt <= nxt == ISSUE_WR;
      mem_write <= nxt == ISSUE_WR;
      busy <= nxt != IDLE;
      fetch_valid <= rd_done;
      if (rd_done) fetch_data <= mem_rdata;
      // address/data buses only move on a grant so the RAM sees a stable bus when idle
      if (state == IDLE && nxt != IDLE) mem_address <= pick_ld ? ld_addr : fetch_addr;
      if (state == IDLE && nxt == ISSUE_WR) mem_wdata <= ld_wdata;
    end
  end
endmodule
